// File: rtl/inst_enc.sv
// rtl/inst_enc.sv - RV32 field-bundle instruction encoder with output word FIFO
// Illegal bundles are consumed, not buffered, and flagged by a one-cycle err pulse.
module inst_enc #(
   parameter int FIFO_DEPTH = 2,
   parameter int COUNT_W    = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [2:0]         fmt,
   input  logic [6:0]         opcode,
   input  logic [2:0]         func3,
   input  logic [6:0]         func7,
   input  logic [4:0]         rs1,
   input  logic [4:0]         rs2,
   input  logic [4:0]         rd,
   input  logic [31:0]        imm,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [31:0]        inst,
   output logic               err,
   output logic [COUNT_W-1:0] inst_count
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [AW-1:0]    PTR_ONE = 1;
   localparam logic [AW:0]      OCC_ONE = 1;
   localparam logic [COUNT_W-1:0] CNT_ONE = 1;

   logic [31:0]   mem [FIFO_DEPTH];
   logic [AW-1:0] wptr;
   logic [AW-1:0] rptr;
   logic [AW:0]   occ;
   logic [31:0]   enc;
   logic          legal;
   logic          full;
   logic          take;
   logic          push;
   logic          pop;

   always_comb begin
      enc = '0;
      case (fmt)
         3'd0: enc = {func7, rs2, rs1, func3, rd, opcode};
         3'd1: enc = {imm[11:0], rs1, func3, rd, opcode};
         3'd2: enc = {imm[11:5], rs2, rs1, func3, imm[4:0], opcode};
         3'd3: enc = {imm[12], imm[10:5], rs2, rs1, func3, imm[4:1], imm[11], opcode};
         3'd4: enc = {imm[31:12], rd, opcode};
         3'd5: enc = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
         3'd6: enc = {7'b0000001, rs2, rs1, 3'b001, rd, 7'b0101011};
         default: enc = '0;
      endcase
   end

   // LWPOSTINC forces its own opcode, so the low-bits check only applies to 0-5.
   assign legal = (fmt == 3'd6) || ((fmt != 3'd7) && (opcode[1:0] == 2'b11));

   assign full      = (32'(occ) == FIFO_DEPTH);
   assign in_ready  = !full;
   assign out_valid = (occ != '0);
   assign inst      = out_valid ? mem[rptr] : '0;
   assign take      = in_valid && in_ready;
   assign push      = take && legal;
   assign pop       = out_valid && out_ready;

   always_ff @(posedge clk) begin
      if (push) mem[wptr] <= enc;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr       <= '0;
         rptr       <= '0;
         occ        <= '0;
         err        <= 1'b0;
         inst_count <= '0;
      end else begin
         err <= take && !legal;
         if (push) wptr <= wptr + PTR_ONE;
         if (pop) begin
            rptr       <= rptr + PTR_ONE;
            inst_count <= inst_count + CNT_ONE;
         end
         if (push && !pop)      occ <= occ + OCC_ONE;
         else if (!push && pop) occ <= occ - OCC_ONE;
      end
   end

endmodule

// File: tb/tb_inst_enc.sv
// tb/tb_inst_enc.sv - directed self-checking bench for inst_enc
// Inputs change on the falling edge; outputs are sampled 1 ns after the rising edge.
module tb_inst_enc;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [2:0]  fmt;
   logic [6:0]  opcode;
   logic [2:0]  func3;
   logic [6:0]  func7;
   logic [4:0]  rs1;
   logic [4:0]  rs2;
   logic [4:0]  rd;
   logic [31:0] imm;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] inst;
   logic        err;
   logic [3:0]  inst_count;

   int          checks = 0;
   int          errors = 0;
   logic [3:0]  exp_count;

   inst_enc #(.FIFO_DEPTH(2), .COUNT_W(4)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .fmt(fmt), .opcode(opcode), .func3(func3), .func7(func7),
      .rs1(rs1), .rs2(rs2), .rd(rd), .imm(imm),
      .out_valid(out_valid), .out_ready(out_ready), .inst(inst),
      .err(err), .inst_count(inst_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp_v);
      end
   endtask

   task automatic put(input logic [2:0] f, input logic [6:0] op, input logic [2:0] f3,
                      input logic [6:0] f7, input logic [4:0] a, input logic [4:0] b,
                      input logic [4:0] d, input logic [31:0] im);
      fmt = f; opcode = op; func3 = f3; func7 = f7;
      rs1 = a; rs2 = b; rd = d; imm = im;
      in_valid = 1'b1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   // One bundle through an always-ready sink: word visible after one edge, gone after the next.
   task automatic send_one(input string tag, input logic [2:0] f, input logic [6:0] op,
                           input logic [2:0] f3, input logic [6:0] f7, input logic [4:0] a,
                           input logic [4:0] b, input logic [4:0] d, input logic [31:0] im,
                           input logic [31:0] word);
      @(negedge clk);
      put(f, op, f3, f7, a, b, d, im);
      tick();
      chk({tag, " inst"}, inst, word);
      chk({tag, " out_valid"}, {31'b0, out_valid}, 32'd1);
      idle();
      tick();
      exp_count = exp_count + 4'd1;
      chk({tag, " count"}, {28'b0, inst_count}, {28'b0, exp_count});
      chk({tag, " drained"}, {31'b0, out_valid}, 32'd0);
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      fmt = '0; opcode = '0; func3 = '0; func7 = '0;
      rs1 = '0; rs2 = '0; rd = '0; imm = '0;
      exp_count = '0;
      #2;
      chk("rst out_valid", {31'b0, out_valid}, 32'd0);
      chk("rst inst", inst, 32'd0);
      chk("rst err", {31'b0, err}, 32'd0);
      chk("rst count", {28'b0, inst_count}, 32'd0);
      chk("rst in_ready", {31'b0, in_ready}, 32'd1);

      // Bundle presented in the reset deassertion cycle
      @(negedge clk);
      rst = 1'b0;
      put(3'd0, 7'h33, 3'd0, 7'h00, 5'd1, 5'd2, 5'd3, 32'hDEAD_BEEF);
      tick();
      chk("deassert inst", inst, 32'h0020_81B3);
      chk("deassert out_valid", {31'b0, out_valid}, 32'd1);
      chk("deassert count", {28'b0, inst_count}, 32'd0);
      idle();
      tick();
      exp_count = 4'd1;
      chk("add count", {28'b0, inst_count}, 32'd1);
      chk("add drained inst", inst, 32'd0);

      send_one("I", 3'd1, 7'h13, 3'd0, 7'h7F, 5'd0, 5'd31, 5'd5, 32'hFFFF_FFFF, 32'hFFF0_0293);
      send_one("B", 3'd3, 7'h63, 3'd0, 7'h55, 5'd1, 5'd2, 5'd9, 32'd8, 32'h0020_8463);
      send_one("LWPI", 3'd6, 7'h00, 3'd7, 7'h7F, 5'd10, 5'd0, 5'd4, 32'h1234_5678, 32'h0205_122B);
      send_one("S", 3'd2, 7'h23, 3'd2, 7'h7F, 5'd1, 5'd2, 5'd17, 32'd12, 32'h0020_A623);
      send_one("U", 3'd4, 7'h37, 3'd7, 7'h7F, 5'd9, 5'd9, 5'd5, 32'h1234_5000, 32'h1234_52B7);
      send_one("J", 3'd5, 7'h6F, 3'd7, 7'h7F, 5'd9, 5'd9, 5'd0, 32'hFFFF_FFFC, 32'hFFDF_F06F);

      // Simultaneous push and pop keeps a single word in flight
      @(negedge clk);
      put(3'd0, 7'h33, 3'd0, 7'h00, 5'd1, 5'd2, 5'd3, 32'd0);
      tick();
      chk("b2b first", inst, 32'h0020_81B3);
      @(negedge clk);
      put(3'd1, 7'h13, 3'd0, 7'h00, 5'd0, 5'd0, 5'd5, 32'hFFFF_FFFF);
      tick();
      exp_count = exp_count + 4'd1;
      chk("b2b second", inst, 32'hFFF0_0293);
      chk("b2b count", {28'b0, inst_count}, {28'b0, exp_count});
      chk("b2b in_ready", {31'b0, in_ready}, 32'd1);
      idle();
      tick();
      exp_count = exp_count + 4'd1;
      chk("b2b drained", {31'b0, out_valid}, 32'd0);

      // Backpressure: depth 2 fills, third bundle is refused, drain in order
      @(negedge clk);
      out_ready = 1'b0;
      put(3'd0, 7'h33, 3'd0, 7'h00, 5'd1, 5'd2, 5'd3, 32'd0);
      tick();
      chk("bp w1", inst, 32'h0020_81B3);
      @(negedge clk);
      put(3'd1, 7'h13, 3'd0, 7'h00, 5'd0, 5'd0, 5'd5, 32'hFFFF_FFFF);
      tick();
      chk("bp full in_ready", {31'b0, in_ready}, 32'd0);
      chk("bp hold w1", inst, 32'h0020_81B3);
      @(negedge clk);
      put(3'd3, 7'h63, 3'd0, 7'h00, 5'd1, 5'd2, 5'd0, 32'd8);
      tick();
      chk("bp refused in_ready", {31'b0, in_ready}, 32'd0);
      chk("bp still w1", inst, 32'h0020_81B3);
      chk("bp count", {28'b0, inst_count}, {28'b0, exp_count});
      idle();
      out_ready = 1'b1;
      tick();
      exp_count = exp_count + 4'd1;
      chk("bp drain w2", inst, 32'hFFF0_0293);
      tick();
      exp_count = exp_count + 4'd1;
      chk("bp drain empty", {31'b0, out_valid}, 32'd0);
      chk("bp drain count", {28'b0, inst_count}, {28'b0, exp_count});

      // Illegal bundles: err pulses, nothing enqueued
      @(negedge clk);
      put(3'd7, 7'h33, 3'd0, 7'h00, 5'd1, 5'd2, 5'd3, 32'd0);
      tick();
      chk("ill fmt7 err", {31'b0, err}, 32'd1);
      chk("ill fmt7 out_valid", {31'b0, out_valid}, 32'd0);
      @(negedge clk);
      put(3'd0, 7'h30, 3'd0, 7'h00, 5'd1, 5'd2, 5'd3, 32'd0);
      tick();
      chk("ill opc err", {31'b0, err}, 32'd1);
      chk("ill opc out_valid", {31'b0, out_valid}, 32'd0);
      idle();
      tick();
      chk("ill err clear", {31'b0, err}, 32'd0);
      chk("ill count", {28'b0, inst_count}, {28'b0, exp_count});

      // Async reset with two words buffered
      @(negedge clk);
      out_ready = 1'b0;
      put(3'd0, 7'h33, 3'd0, 7'h00, 5'd1, 5'd2, 5'd3, 32'd0);
      tick();
      @(negedge clk);
      put(3'd1, 7'h13, 3'd0, 7'h00, 5'd0, 5'd0, 5'd5, 32'hFFFF_FFFF);
      tick();
      idle();
      #2;
      rst = 1'b1;
      #1;
      chk("arst out_valid", {31'b0, out_valid}, 32'd0);
      chk("arst count", {28'b0, inst_count}, 32'd0);
      chk("arst in_ready", {31'b0, in_ready}, 32'd1);
      chk("arst inst", inst, 32'd0);
      exp_count = '0;
      @(negedge clk);
      rst = 1'b0;
      out_ready = 1'b1;
      put(3'd0, 7'h33, 3'd0, 7'h00, 5'd1, 5'd2, 5'd3, 32'd0);
      tick();
      chk("post-rst inst", inst, 32'h0020_81B3);
      idle();
      tick();
      exp_count = exp_count + 4'd1;
      chk("post-rst count", {28'b0, inst_count}, {28'b0, exp_count});

      // Counter wraps from all-ones back to zero
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         put(3'd0, 7'h33, 3'd0, 7'h00, 5'd1, 5'd2, 5'd3, 32'd0);
         tick();
         idle();
         tick();
         exp_count = exp_count + 4'd1;
         chk("wrap count", {28'b0, inst_count}, {28'b0, exp_count});
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/inst_enc.md
INST_ENC -- requirements
Module: inst_enc

Interface
REQ-001 Parameter FIFO_DEPTH, default 2, SHALL set the number of encoded-word output buffer entries (power of two, >= 2).
REQ-002 Parameter COUNT_W, default 16, SHALL set the issued-instruction counter width.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  SHALL be the asynchronous, active-high reset.
REQ-005 in_valid  input  1  SHALL mark the field bundle as valid.
REQ-006 in_ready  output  1  SHALL indicate the block can accept a bundle.
REQ-007 fmt  input  3  SHALL select the format: 0 R, 1 I, 2 S, 3 B, 4 U, 5 J, 6 LWPOSTINC, 7 illegal.
REQ-008 opcode  input  7;  func3  input  3;  func7  input  7  SHALL carry the instruction fields.
REQ-009 rs1, rs2, rd  input  5 each  SHALL carry the register indices.
REQ-010 imm  input  32  SHALL carry the immediate, byte-offset form, sign already applied.
REQ-011 out_valid  output  1  SHALL mark inst as valid.
REQ-012 out_ready  input  1  SHALL indicate the downstream decoder or memory accepts inst.
REQ-013 inst  output  32  SHALL be the encoded instruction word.
REQ-014 err  output  1  SHALL be a one-cycle illegal-bundle pulse.
REQ-015 inst_count  output  COUNT_W  SHALL count completed output transfers.

Function
REQ-016 Input transfer SHALL occur when in_valid && in_ready; in_ready = !full, with no same-cycle pass-through when full, even if a pop occurs.
REQ-017 Encoding for R SHALL be func7|rs2|rs1|func3|rd|opcode, from bit 31 down to bit 0.
REQ-018 Encoding for I SHALL be imm[11:0]|rs1|func3|rd|opcode.
REQ-019 Encoding for S SHALL be imm[11:5]|rs2|rs1|func3|imm[4:0]|opcode.
REQ-020 Encoding for B SHALL be imm[12]|imm[10:5]|rs2|rs1|func3|imm[4:1]|imm[11]|opcode.
REQ-021 Encoding for U SHALL be imm[31:12]|rd|opcode.
REQ-022 Encoding for J SHALL be imm[20]|imm[10:1]|imm[11]|imm[19:12]|rd|opcode.
REQ-023 LWPOSTINC SHALL use the R layout with forced opcode 7'b0101011, func3 3'b001 and func7 7'b0000001; the opcode, func3 and func7 inputs SHALL be ignored.
REQ-024 The ignored fields of other formats SHALL be ignored.
REQ-025 A bundle SHALL be illegal when fmt==7, or when fmt is 0-5 and opcode[1:0]!=2'b11.
REQ-026 An illegal bundle SHALL still be consumed under the REQ-016 rule and SHALL NOT be enqueued.
REQ-027 err SHALL be high for exactly the cycle after an illegal transfer.
REQ-028 Latency: a legal word accepted at edge N SHALL be presented on inst with out_valid high after edge N if the FIFO was empty.
REQ-029 Words SHALL be presented in FIFO order.
REQ-030 While out_valid && !out_ready, inst SHALL remain stable.
REQ-031 Output transfer SHALL occur when out_valid && out_ready.
REQ-032 inst_count SHALL increment by 1 per output transfer and wrap from all-ones to 0.
REQ-033 With the FIFO non-full, simultaneous push and pop SHALL keep occupancy unchanged.
REQ-034 A pop from an empty FIFO SHALL NOT occur: out_valid is low when empty.
REQ-035 FIFO read and write pointers SHALL wrap modulo FIFO_DEPTH.

Reset
REQ-036 While rst is high: out_valid=0, inst=0, err=0, inst_count=0, FIFO empty, in_ready=1 immediately.
REQ-037 Assertion of rst mid-operation SHALL discard all buffered words.
REQ-038 A bundle presented in the deassertion cycle SHALL be accepted at the first clk edge after rst falls.

Verification
REQ-039 R, add x3,x1,x2 (opcode 0x33, func3 0, func7 0, rs1 1, rs2 2, rd 3), out_ready=1 -> inst=0x002081B3 one cycle later, inst_count=1.
REQ-040 I, opcode 0x13, rd 5, rs1 0, imm 0xFFFFFFFF -> inst=0xFFF00293; B, opcode 0x63, rs1 1, rs2 2, imm 8 -> inst=0x00208463.
REQ-041 LWPOSTINC, rd 4, rs1 10, rs2 0, opcode input 0x00 -> inst=0x0205122B.
REQ-042 out_ready=0, three legal bundles offered back-to-back -> two accepted, then in_ready=0; inst holds the first word; releasing out_ready drains the words in order and inst_count=2.
REQ-043 fmt=7, then fmt=0 with opcode 0x30 -> one err pulse each, nothing enqueued, out_valid stays 0.
REQ-044 rst asserted with 2 words buffered -> out_valid=0 and inst_count=0 asynchronously; post-reset encode of 0x002081B3 is correct.
